// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter: FSM state encoding,
// flag bit positions within {Z,C,V,N} and default datapath widths.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 0;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_OPW   = 3;

    // Requester index to a 2-bit one-hot vector.
    function automatic logic [1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bus bundle for the ALU sharing arbiter: two requester channels, the
// shared-ALU operand/result path and the response channel.
// slave  = arbiter side, master = requesters plus the ALU itself.
interface alu_share_arbiter_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned OPW   = DEF_OPW
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*OPW-1:0]   req_op;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;

    logic [OPW-1:0]     alu_op;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [WIDTH-1:0]   alu_result;
    logic [3:0]         alu_flags;

    logic [1:0]         rsp_valid;
    logic [1:0]         rsp_ready;
    logic [WIDTH-1:0]   rsp_result;
    logic [3:0]         rsp_flags;

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        input  alu_result, alu_flags,
        input  rsp_ready,
        output req_ready,
        output alu_op, alu_a, alu_b,
        output rsp_valid, rsp_result, rsp_flags
    );

    modport master (
        output req_valid, req_op, req_a, req_b,
        output alu_result, alu_flags,
        output rsp_ready,
        input  req_ready,
        input  alu_op, alu_a, alu_b,
        input  rsp_valid, rsp_result, rsp_flags
    );

endinterface

// File: rtl/alu_share_arbiter_rr_arbiter2.sv
// Two-way round-robin grant. A lone requester wins outright; on a tie the
// requester not granted last wins. The pointer moves only on a completed
// request handshake (advance).
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // Index of the requester granted most recently; 1 after reset so
    // requester 0 wins the first tie.
    logic last;

    // Grant selection from current requests and the pointer.
    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

    // Pointer update on accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (advance) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Arbitrates two requesters onto one combinational ALU. One transaction in
// flight: IDLE (grant) -> EXEC (one cycle, ALU driven) -> RESP (hold until
// the owner accepts). Optional feature macro: ALU_ARB_STICKY_FLAGS_EN adds
// per-requester sticky C/V flags and the sticky_clr input.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned OPW   = DEF_OPW
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef ALU_ARB_STICKY_FLAGS_EN
    input  logic [1:0] sticky_clr,
`endif
    alu_share_arbiter_if.slave bus
);

    state_t           state;
    logic             owner;
    logic [OPW-1:0]   alu_op_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [1:0]       rsp_valid_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic [3:0]       rsp_flags_q;

    logic [1:0]       grant;
    logic             hs;
    logic             hs_id;
    logic [OPW-1:0]   sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [3:0]       flags_next;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.req_valid),
        .advance (hs),
        .grant   (grant)
    );

    // Grant is only offered in IDLE and never while reset is asserted.
    assign bus.req_ready = (state == IDLE && rst_n) ? grant : '0;
    assign hs            = |(bus.req_valid & bus.req_ready);
    assign hs_id         = bus.req_ready[1];

    // Winner operand selection.
    always_comb begin
        sel_op = hs_id ? bus.req_op[2*OPW-1:OPW]     : bus.req_op[OPW-1:0];
        sel_a  = hs_id ? bus.req_a[2*WIDTH-1:WIDTH]  : bus.req_a[WIDTH-1:0];
        sel_b  = hs_id ? bus.req_b[2*WIDTH-1:WIDTH]  : bus.req_b[WIDTH-1:0];
    end

`ifdef ALU_ARB_STICKY_FLAGS_EN
    logic [1:0] sticky_c;
    logic [1:0] sticky_v;
    logic [1:0] sticky_c_nxt;
    logic [1:0] sticky_v_nxt;

    // Clear first, then OR in the capture so a same-cycle set wins.
    always_comb begin
        sticky_c_nxt = sticky_c & ~sticky_clr;
        sticky_v_nxt = sticky_v & ~sticky_clr;
        if (state == EXEC) begin
            sticky_c_nxt[owner] = sticky_c_nxt[owner] | bus.alu_flags[FLAG_C];
            sticky_v_nxt[owner] = sticky_v_nxt[owner] | bus.alu_flags[FLAG_V];
        end
        flags_next         = bus.alu_flags;
        flags_next[FLAG_C] = sticky_c_nxt[owner];
        flags_next[FLAG_V] = sticky_v_nxt[owner];
    end

    // Sticky flag storage per requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_c <= '0;
            sticky_v <= '0;
        end else begin
            sticky_c <= sticky_c_nxt;
            sticky_v <= sticky_v_nxt;
        end
    end
`else
    assign flags_next = bus.alu_flags;
`endif

    // Transaction FSM with registered ALU-side and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner        <= 1'b0;
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        owner    <= hs_id;
                        alu_op_q <= sel_op;
                        alu_a_q  <= sel_a;
                        alu_b_q  <= sel_b;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    alu_op_q     <= '0;
                    alu_a_q      <= '0;
                    alu_b_q      <= '0;
                    rsp_result_q <= bus.alu_result;
                    rsp_flags_q  <= flags_next;
                    rsp_valid_q  <= id_to_onehot(owner);
                    state        <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready[owner]) begin
                        rsp_valid_q <= '0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.alu_op     = alu_op_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width.
REQ-002 Parameter: OPW, default 3, ALU opcode width.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-007 req_ready  output  2  per-requester accept; one-hot or zero.
REQ-008 req_op  input  2*OPW  opcodes; slice i = requester i.
REQ-009 req_a, req_b  input  2*WIDTH each  operands; slice i = requester i.
REQ-010 alu_op  output  OPW  opcode to the shared ALU.
REQ-011 alu_a, alu_b  output  WIDTH each  operands to the shared ALU.
REQ-012 alu_result  input  WIDTH  combinational ALU result.
REQ-013 alu_flags  input  4  {Z,C,V,N} from the flag unit; C and V are already 0 for logic ops.
REQ-014 rsp_valid  output  2  response valid; at most one bit set.
REQ-015 rsp_ready  input  2  per-requester response accept.
REQ-016 rsp_result  output  WIDTH  captured result; meaningful only while any rsp_valid bit is 1.
REQ-017 rsp_flags  output  4  captured {Z,C,V,N}.

Function
REQ-018 FSM states: IDLE, EXEC, RESP; one transaction in flight at a time.
REQ-019 IDLE: req_ready = grant one-hot (combinational from req_valid and rr pointer); handshake = req_valid[i] & req_ready[i].
REQ-020 Arbitration: single requester wins outright; both valid grants the requester not granted last; rr pointer updates only on a completed request handshake.
REQ-021 On handshake: capture op/a/b of the winner plus owner id; next state EXEC.
REQ-022 EXEC (exactly one cycle): alu_op/alu_a/alu_b driven from captured registers; alu_result and alu_flags registered at end of cycle; next state RESP.
REQ-023 Outside EXEC: alu_op/alu_a/alu_b driven to 0.
REQ-024 RESP: rsp_valid[owner] = 1; rsp_result/rsp_flags stable until rsp_ready[owner] = 1; then IDLE.
REQ-025 rsp_ready on the non-owner bit is ignored.
REQ-026 Latency: request handshake cycle N -> rsp_valid visible in cycle N+2.
REQ-027 req_ready = 0 in EXEC and RESP; a new request is accepted no earlier than the cycle after the response handshake.
REQ-028 Requests held while not granted are neither dropped nor reordered.

Reset
REQ-029 Asserting rst_n = 0 at any time, including mid-EXEC or mid-RESP, abandons the transaction; no response is issued.
REQ-030 Reset values: state IDLE; rr pointer = 1 (requester 0 wins the first tie); req_ready, rsp_valid, rsp_result, rsp_flags, alu_op, alu_a, alu_b, and sticky bits all 0.

Configuration
REQ-031 Macro ALU_ARB_STICKY_FLAGS_EN.
- Defined: per-requester sticky C and V registers, set by captured C/V; rsp_flags C/V report the sticky value for the owner. Adds input sticky_clr (2 bits) to clear requester i's sticky bits. Clear and set in the same cycle leave the new capture value.
- Undefined: rsp_flags equals the captured alu_flags; no sticky_clr port.

Structure
REQ-032 Shared package alu_pkg holds the FSM state enum, flag bit index constants (Z=3, C=2, V=1, N=0), and default WIDTH/OPW.
REQ-033 Sub-module rr_arbiter2 provides the 2-way round-robin grant and pointer; the FSM stays in alu_share_arbiter.

Verification
REQ-034 Scenario 1: req 0 only, op=ADD, a=7, b=1, ALU model returns 8 with flags V=1,N=1 -> rsp_valid=01 at N+2, rsp_result=8, rsp_flags=0011.
REQ-035 Scenario 2: both valid from reset -> order of grants is 0, 1, 0 over three back-to-back transactions.
REQ-036 Scenario 3: rsp_ready held 0 for 5 cycles -> rsp_result/rsp_flags stable, req_ready=00 throughout.
REQ-037 Scenario 4: rst_n pulsed low during EXEC -> all outputs 0 immediately; no rsp_valid after release.
REQ-038 Scenario 5 (macro defined): requester 1 ADD sets C=1, then AND with C=0 -> second rsp_flags C=1; after sticky_clr=10, next AND -> C=0.
REQ-039 Scenario 6: rsp_ready=10 while owner is 0 -> response is not consumed and rsp_valid stays 01.
